// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU operation scheduler:
//   - opcode width and the first multi-cycle opcode
//   - requester ID width
//   - scheduler FSM state encoding
//   - helper that classifies an opcode as single- or multi-cycle
package alu_pkg;

    localparam int OP_W = 4;
    localparam int ID_W = 3;

    // Opcodes at or above this value need MC_LAT execute cycles.
    localparam logic [OP_W-1:0] OP_MC_BASE = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    function automatic logic is_multi_cycle(input logic [OP_W-1:0] op);
        return (op >= OP_MC_BASE);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick among NREQ requesters. The search starts
// at the requester after the previous winner and wraps around, so the
// previous winner itself is considered last.
// Ports:
//   req_valid_i  per-requester valid
//   last_i       index of the previous winner
//   grant_o      one-hot grant (all zero when nobody is valid)
//   idx_o        index of the granted requester
//   any_o        high when some requester was picked
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [ID_W-1:0] last_i,
    output logic [NREQ-1:0] grant_o,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o
);

    // Walk offsets 1..NREQ from the last winner; the first valid one wins.
    always_comb begin
        int cand;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = (int'(last_i) + off) % NREQ;
            if (!any_o && req_valid_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = ID_W'(cand);
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler
// Shares one ALU result datapath between NREQ requesters. A round-robin
// winner is granted in IDLE, its opcode/operands drive the ALU during EXEC
// for 1 or MC_LAT cycles, and the captured result is offered in RESP on a
// valid/ready channel tagged with the requester ID.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/op/a/b      packed per-requester requests (requester i at slice i)
//   req_ready             one-hot grant pulse, only in IDLE
//   alu_sel/alu_a/alu_b   ALU select and operands
//   alu_y                 ALU result
//   rsp_valid/ready       response handshake
//   rsp_id/rsp_data       response tag and captured result
//   busy                  high whenever the scheduler is not in IDLE
module alu_op_scheduler
    import alu_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int W      = 16,
    parameter int MC_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*OP_W-1:0] req_op,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [OP_W-1:0]      alu_sel,
    output logic [W-1:0]         alu_a,
    output logic [W-1:0]         alu_b,
    input  logic [W-1:0]         alu_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [W-1:0]         rsp_data,
    output logic                 busy
);

    localparam int CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_MC   = CNT_W'(MC_LAT - 1);
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NREQ - 1);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [W-1:0]      rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]   arb_grant;
    logic [ID_W-1:0]   arb_idx;
    logic              arb_any;
    logic [OP_W-1:0]   win_op;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_valid_i (req_valid),
        .last_i      (last_q),
        .grant_o     (arb_grant),
        .idx_o       (arb_idx),
        .any_o       (arb_any)
    );

    assign win_op = req_op[OP_W*arb_idx +: OP_W];

    // State, counter and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_q     <= LAST_RST;
            id_q       <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            id_q       <= id_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Next-state logic: latch the winner in IDLE, count down in EXEC,
    // hold the response in RESP until it is accepted.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    op_d    = win_op;
                    a_d     = req_a[W*arb_idx +: W];
                    b_d     = req_b[W*arb_idx +: W];
                    id_d    = arb_idx;
                    last_d  = arb_idx;
                    cnt_d   = is_multi_cycle(win_op) ? CNT_MC : '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    rsp_data_d = alu_y;
                    rsp_id_d   = id_q;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The grant is gated with rst_n so no requester sees a handshake while
    // reset is asserted, even though the FSM is parked in IDLE.
    assign req_ready = (state_q == S_IDLE && rst_n) ? arb_grant : '0;
    assign alu_sel   = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb_alu_op_scheduler
// Directed bench for alu_op_scheduler (NREQ=4, W=16, MC_LAT=3). A small
// behavioural ALU answers the scheduler; for multi-cycle opcodes its result
// also carries the number of EXEC cycles elapsed, so the captured value
// shows which cycle the scheduler sampled.
module tb_alu_op_scheduler;

    localparam int NREQ   = 4;
    localparam int W      = 16;
    localparam int MC_LAT = 3;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*4-1:0] req_op;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [3:0]        alu_sel;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [W-1:0]      alu_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_id;
    logic [W-1:0]      rsp_data;
    logic              busy;

    int checkCount = 0;
    int passCount  = 0;
    logic [15:0] execCycles;

    alu_op_scheduler #(
        .NREQ   (NREQ),
        .W      (W),
        .MC_LAT (MC_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .alu_sel   (alu_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // 100 MHz-style clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts EXEC cycles of the current operation (busy and no response yet).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            execCycles <= '0;
        else if (busy && !rsp_valid)
            execCycles <= execCycles + 16'd1;
        else
            execCycles <= '0;
    end

    // Behavioural ALU: a few distinct functions, multi-cycle ops add the
    // elapsed EXEC cycle count.
    always_comb begin
        case (alu_sel)
            4'd0:    alu_y = alu_a & alu_b;
            4'd2:    alu_y = alu_a + alu_b;
            4'd5:    alu_y = alu_a - alu_b;
            4'd7:    alu_y = alu_a | alu_b;
            4'd13:   alu_y = alu_a * alu_b;
            default: alu_y = alu_a ^ alu_b;
        endcase
        if (alu_sel >= 4'd12)
            alu_y = alu_y + execCycles;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input int idx, input logic valid, input logic [3:0] op,
                                 input logic [15:0] a, input logic [15:0] b);
        req_valid[idx]    = valid;
        req_op[4*idx +: 4] = op;
        req_a[W*idx +: W]  = a;
        req_b[W*idx +: W]  = b;
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"},   32'(req_ready), 32'h0);
        checkOutput({tag, "_sel"},     32'(alu_sel),   32'h0);
        checkOutput({tag, "_a"},       32'(alu_a),     32'h0);
        checkOutput({tag, "_b"},       32'(alu_b),     32'h0);
        checkOutput({tag, "_rvalid"},  32'(rsp_valid), 32'h0);
        checkOutput({tag, "_rid"},     32'(rsp_id),    32'h0);
        checkOutput({tag, "_rdata"},   32'(rsp_data),  32'h0);
        checkOutput({tag, "_busy"},    32'(busy),      32'h0);
    endtask

    // Hand-computed rotation table: grant pattern, op, operands, result.
    logic [3:0]  expReady [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0]  expOp    [5] = '{4'd2, 4'd0, 4'd5, 4'd7, 4'd2};
    logic [15:0] expA     [5] = '{16'h0003, 16'h00F0, 16'h0100, 16'h1200, 16'h0003};
    logic [15:0] expData  [5] = '{16'h0007, 16'h0030, 16'h00FF, 16'h1234, 16'h0007};
    logic [2:0]  expId    [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        applyStimulus(0, 1'b1, 4'd2, 16'h0003, 16'h0004);
        applyStimulus(1, 1'b1, 4'd0, 16'h00F0, 16'h0030);
        applyStimulus(2, 1'b1, 4'd5, 16'h0100, 16'h0001);
        applyStimulus(3, 1'b1, 4'd7, 16'h1200, 16'h0034);

        // Reset held with all requesters valid.
        stepCycle();
        stepCycle();
        #1;
        checkAllZero("rst");
        rst_n = 1'b1;

        // Rotation 0,1,2,3,0 with responses accepted immediately.
        for (int g = 0; g < 5; g++) begin
            #1;
            checkOutput("grant", 32'(req_ready), 32'(expReady[g]));
            checkOutput("idleBusy", 32'(busy), 32'h0);
            stepCycle();
            #1;
            checkOutput("execSel", 32'(alu_sel), 32'(expOp[g]));
            checkOutput("execA", 32'(alu_a), 32'(expA[g]));
            checkOutput("execReady", 32'(req_ready), 32'h0);
            checkOutput("execRspValid", 32'(rsp_valid), 32'h0);
            if (g == 4)
                req_valid = '0;
            stepCycle();
            #1;
            checkOutput("rspValid", 32'(rsp_valid), 32'h1);
            checkOutput("rspId", 32'(rsp_id), 32'(expId[g]));
            checkOutput("rspData", 32'(rsp_data), 32'(expData[g]));
            stepCycle();
        end
        #1;
        checkOutput("quietReady", 32'(req_ready), 32'h0);
        checkOutput("quietBusy", 32'(busy), 32'h0);

        // Multi-cycle op from requester 2, response back-pressured.
        applyStimulus(2, 1'b1, 4'd13, 16'h0010, 16'h0020);
        rsp_ready = 1'b0;
        #1;
        checkOutput("mcGrant", 32'(req_ready), 32'h4);
        stepCycle();
        req_valid[2] = 1'b0;
        for (int k = 0; k < MC_LAT; k++) begin
            #1;
            checkOutput("mcSel", 32'(alu_sel), 32'd13);
            checkOutput("mcRspValid", 32'(rsp_valid), 32'h0);
            stepCycle();
        end
        applyStimulus(1, 1'b1, 4'd2, 16'h0011, 16'h0022);
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput("bpRspValid", 32'(rsp_valid), 32'h1);
            checkOutput("bpRspData", 32'(rsp_data), 32'h0202);
            checkOutput("bpRspId", 32'(rsp_id), 32'h2);
            checkOutput("bpReady", 32'(req_ready), 32'h0);
            checkOutput("bpSel", 32'(alu_sel), 32'd13);
            stepCycle();
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("bpLastReady", 32'(req_ready), 32'h0);
        stepCycle();
        #1;
        checkOutput("bpNextGrant", 32'(req_ready), 32'h2);
        checkOutput("bpIdleRspValid", 32'(rsp_valid), 32'h0);
        stepCycle();
        req_valid[1] = 1'b0;
        stepCycle();
        #1;
        checkOutput("req1RspId", 32'(rsp_id), 32'h1);
        checkOutput("req1RspData", 32'(rsp_data), 32'h0033);
        stepCycle();

        // Reset in the middle of a multi-cycle op from requester 1.
        applyStimulus(1, 1'b1, 4'd14, 16'h00FF, 16'h0F0F);
        #1;
        checkOutput("abortGrant", 32'(req_ready), 32'h2);
        stepCycle();
        req_valid[1] = 1'b0;
        applyStimulus(0, 1'b1, 4'd2, 16'h0001, 16'h0001);
        applyStimulus(2, 1'b1, 4'd2, 16'h0002, 16'h0002);
        #1;
        checkOutput("abortBusy", 32'(busy), 32'h1);
        stepCycle();
        #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("abort");
        rst_n = 1'b1;
        #1;
        checkOutput("postRstGrant", 32'(req_ready), 32'h1);
        stepCycle();
        req_valid[0] = 1'b0;
        #1;
        checkOutput("postRstExecRspValid", 32'(rsp_valid), 32'h0);
        checkOutput("postRstSel", 32'(alu_sel), 32'd2);
        stepCycle();
        #1;
        checkOutput("postRstRspValid", 32'(rsp_valid), 32'h1);
        checkOutput("postRstRspId", 32'(rsp_id), 32'h0);
        checkOutput("postRstRspData", 32'(rsp_data), 32'h0002);
        stepCycle();
        req_valid[2] = 1'b0;
        #1;
        checkOutput("droppedReq2", 32'(req_ready), 32'h0);

        // Requester 3 valid for one busy cycle only.
        applyStimulus(0, 1'b1, 4'd0, 16'hFFFF, 16'h00AA);
        #1;
        checkOutput("shortGrant0", 32'(req_ready), 32'h1);
        stepCycle();
        req_valid[0] = 1'b0;
        applyStimulus(3, 1'b1, 4'd7, 16'h0001, 16'h0002);
        #1;
        checkOutput("shortBusyReady", 32'(req_ready), 32'h0);
        stepCycle();
        req_valid[3] = 1'b0;
        #1;
        checkOutput("shortRspData", 32'(rsp_data), 32'h00AA);
        checkOutput("shortRspId", 32'(rsp_id), 32'h0);
        stepCycle();
        #1;
        checkOutput("req3Skipped", 32'(req_ready), 32'h0);
        checkOutput("req3SkippedBusy", 32'(busy), 32'h0);
        stepCycle();
        #1;
        checkOutput("req3StillIdle", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_op_scheduler.md
# alu_op_scheduler

- Shares one 16-bit ALU result datapath (16 operation units feeding a 16:1 result mux selected by a 4-bit code) between `NREQ` requesters.
- Arbitrates round-robin, drives the operands and the mux select, and waits the op's latency.
- Captures the mux output and returns it, tagged with the requester ID, over a valid/ready response channel.
- Sits between the instruction-issue logic and the ALU; it is the only driver of the ALU select and operand inputs.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `W`, 16: operand/result width; must match ALU width.
- `MC_LAT`, 3: execute cycles for multi-cycle ops (opcodes 12..15), ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_op`  in  NREQ*4  per-requester opcode (= ALU mux select); requester i at [4i+3:4i].
- `req_a`, `req_b`  in  NREQ*W  per-requester operands, packed the same way.
- `req_ready`  out  NREQ  one-hot grant pulse; the handshake completes when valid and ready are both high.
- `alu_sel`  out  4  ALU result-mux select.
- `alu_a`, `alu_b`  out  W  ALU operands.
- `alu_y`  in  W  ALU result (mux output).
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  3  index of the granted requester.
- `rsp_data`  out  W  captured result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is high, the round-robin pick selects the first requester at or after `last+1` (mod NREQ).
  - `req_ready[winner]` is asserted combinationally in that cycle.
  - Opcode, operands and ID are latched; `cnt` = (op ≥ 12) ? MC_LAT−1 : 0; `last` ← winner; next state EXEC.
- EXEC:
  - `alu_sel/alu_a/alu_b` are driven from the latched registers and stay stable for the whole state.
  - When `cnt==0`: `rsp_data ← alu_y`, `rsp_id ← id`, next state RESP. Otherwise `cnt` decrements.
- RESP:
  - `rsp_valid=1`; `rsp_data/rsp_id` stay stable until accepted.
  - On `rsp_ready`, next state IDLE. No request is accepted in RESP.
- Requesters hold valid and payload stable until granted.
- A requester that drops valid before being granted is legal; it is skipped and not granted.
- `req_ready` is never high outside IDLE and is never asserted to a requester whose valid is low.
- Opcodes 0..11 are single-cycle; 12..15 are multi-cycle. No other decoding is done.

## Timing
- Reset (async assert, sync deassert at the next `clk` edge):
  - State IDLE; `last` = NREQ−1, so requester 0 has priority first.
  - `req_ready=0`, `alu_sel=0`, `alu_a=0`, `alu_b=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `busy=0`.
- Reset mid-operation aborts the op; no response is produced.
- Latency:
  - Grant in cycle t; `rsp_valid` at t+2 for single-cycle ops and at t+1+MC_LAT for multi-cycle ops.
  - Next grant no earlier than the cycle after the `rsp_ready` handshake.
  - Peak throughput: one single-cycle op per 3 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle.
  - With all requesters continuously valid, grants rotate 0,1,2,…,NREQ−1,0.
- Back-pressure: `rsp_ready` low holds RESP indefinitely; `alu_*` holds its last values.

## Structure
- Shared package `alu_pkg`:
  - opcode constants (`OP_MC_BASE=12`);
  - state encoding (`S_IDLE`, `S_EXEC`, `S_RESP`);
  - ID width constant (3).
- Sub-module `rr_arbiter`: parameterised NREQ-way combinational round-robin pick from `req_valid` and `last`, outputting a one-hot grant and an index.
- The FSM, counter and datapath registers are in the top level.

## Test plan
- Reset with all valids high, then release: `req_ready=0001` in the first IDLE cycle.
  - Then req0 op=2, a=0x0003, b=0x0004, with the model ALU returning 0x0007: `rsp_valid` two cycles after the grant, `rsp_id=0`, `rsp_data=0x0007`.
- All 4 requesters valid, single-cycle ops, `rsp_ready` tied high: grant order 0,1,2,3,0, each 3 cycles apart.
- req2 op=13 with MC_LAT=3:
  - `alu_sel=13` held for 3 EXEC cycles;
  - `rsp_valid` 4 cycles after the grant;
  - `rsp_data` equals `alu_y` sampled in the last EXEC cycle.
- `rsp_ready` held low 5 cycles in RESP, with req1 valid:
  - `rsp_valid`/`rsp_data` stable and `req_ready=0` throughout;
  - req1 is granted the cycle after `rsp_ready` rises.
- `rst_n` pulsed low in the middle of a multi-cycle op:
  - all outputs go to 0 immediately;
  - no response is produced;
  - the next grant goes to requester 0.
- req3 valid for one cycle while the block is busy, then dropped: req3 is never granted.
